vec_dot_ctrl: RTL
=================

Name: vec_dot_ctrl

Overview:
Sequencing controller that runs long dot products on the shared 16-lane vec_mul datapath. A job of N beats (N ≤ MAX_BEATS) is streamed in as C-wide x/k chunks over a valid/ready handshake. Each beat is issued into an internal vec_mul instance, and the partial sums are accumulated as they leave the pipeline. One signed result is returned per job on a valid/ready output.

Parameters:
C, 16, lanes per beat (vec_mul width)
W_X, 8, signed activation width per lane
W_K, 8, signed weight width per lane
MAX_BEATS, 64, maximum beats per job
W_Y, W_X+W_K+$clog2(C) (=20), vec_mul output width (derived)
LATENCY, $clog2(C)+1 (=5), vec_mul latency in cycles (derived)
W_N, $clog2(MAX_BEATS+1) (=7), beat-count width (derived)
W_ACC, W_Y+$clog2(MAX_BEATS) (=26), result width (derived)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  job start pulse, sampled in IDLE only
cfg_beats  in  W_N  beats in the job, latched on accepted start
s_valid  in  1  input beat valid
s_ready  out  1  controller accepts beat
s_x  in  C×W_X signed  packed activations
s_k  in  C×W_K signed  packed weights
m_valid  out  1  result valid
m_ready  in  1  result consumer ready
m_data  out  W_ACC signed  dot-product result
busy  out  1  high whenever state ≠ IDLE

Behaviour:
- Reset values: state=IDLE, s_ready=0, m_valid=0, m_data=0, busy=0, accumulator=0, beat counter=0, tag pipeline all 0.
- Reset asserted in any state aborts the job in the next cycle. In-flight vec_mul tags are discarded and never accumulated.
- Internal vec_mul: enable tied to 1. Its x and k inputs are driven with s_x and s_k on an accepted beat (s_valid&&s_ready), and with all zeros otherwise.
- Tag pipeline: a LATENCY-deep shift register clocked every cycle. Its input is the accept signal (s_valid&&s_ready). A beat presented in cycle n produces tag_out=1 in cycle n+LATENCY, aligned with that beat's vec_mul y.
- Accumulate: when tag_out=1, acc <= acc + sign_extend(y) at the end of that cycle. Arithmetic is two's complement and W_ACC is sized so overflow cannot occur.
- FSM:
  - IDLE: s_ready=0. If start && cfg_beats in 1..MAX_BEATS, latch N, clear acc and the beat counter, then go to FEED. If cfg_beats=0 or cfg_beats>MAX_BEATS, start is ignored and the FSM stays in IDLE.
  - FEED: s_ready=1. Each accepted beat increments the counter. When the accepted beat is beat N-1 (0-based), go to DRAIN. s_valid low inserts bubbles with no other effect.
  - DRAIN: s_ready=0. Wait until the tag pipeline is all zero and no tag_out is pending, then go to OUT. acc is final on DRAIN exit.
  - OUT: m_valid=1 and m_data=acc, both held stable until m_ready. The transfer happens on m_valid&&m_ready, after which the FSM goes to IDLE. m_valid drops in the next cycle and m_data keeps its last value.
- start while busy=1 is ignored.
- Timing with s_valid held high: start in cycle s, beats accepted in s+1..s+N, m_valid first high in cycle s+N+LATENCY+1 (s+N+6 for the defaults).
- m_ready held high before OUT has no effect. Back-to-back jobs are possible: start can be accepted in the first IDLE cycle after the transfer.

Test Plan:
1. All lanes x=1, k=1, cfg_beats=4, s_valid held high, m_ready=1 → m_data=64; m_valid rises exactly 10 cycles after the start cycle and stays high for 1 cycle.
2. All lanes x=-128, k=-128, cfg_beats=64 → m_data=16,777,216. Then all lanes x=-128, k=127, cfg_beats=64 → m_data=-16,646,144. Neither result wraps.
3. Random x and k, cfg_beats=7, s_valid toggled with random bubbles (≥3 bubbles) → m_data equals the reference sum of x·k over the 7 accepted beats only, and s_ready is never high outside FEED.
4. Job completes with m_ready held low for 3 cycles → m_valid and m_data stay stable through the stall, then exactly one transfer, then busy=0.
5. rst pulsed for 1 cycle mid-FEED after 3 of 8 beats, followed by a new job with cfg_beats=2, x=k=2 on all lanes → m_data=128, with no contribution from the aborted beats.
6. start with cfg_beats=0 → busy stays 0. start pulsed during DRAIN → ignored, the current result is unchanged and no second job starts.

Source files
------------

// File: rtl/vec_dot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vec_dot_ctrl (with internal vec_mul)
// Brief    : Streams N-beat dot-product jobs through a pipelined 16-lane
//            multiply/adder-tree and accumulates one signed result per job.
// Revision : 1.0  initial release
// ============================================================================

// Pipelined C-lane signed multiply followed by a registered binary adder tree.
// Latency is 1 (products) + log2(C) (tree levels); C must be a power of two.
module vec_mul #(
    parameter int C   = 16,
    parameter int W_X = 8,
    parameter int W_K = 8,
    parameter int W_Y = W_X + W_K + $clog2(C)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic [C*W_X-1:0]      i_x,
    input  logic [C*W_K-1:0]      i_k,
    output logic signed [W_Y-1:0] o_y
);
    localparam int W_P    = W_X + W_K;
    localparam int N_NODE = 2 * C - 1;

    logic signed [W_P-1:0] w_prod [C];
    // Heap-ordered tree: node j sums children 2j+1 and 2j+2, leaves at C-1..2C-2.
    logic signed [W_Y-1:0] r_node [N_NODE];

    always_comb begin
        for (int i = 0; i < C; i++) begin
            w_prod[i] = W_P'($signed(i_x[i*W_X +: W_X])) * W_P'($signed(i_k[i*W_K +: W_K]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < N_NODE; j++) begin
                r_node[j] <= '0;
            end
        end else if (i_en) begin
            for (int i = 0; i < C; i++) begin
                r_node[C-1+i] <= {{(W_Y-W_P){w_prod[i][W_P-1]}}, w_prod[i]};
            end
            for (int j = 0; j < C - 1; j++) begin
                r_node[j] <= r_node[2*j+1] + r_node[2*j+2];
            end
        end
    end

    assign o_y = r_node[0];
endmodule

module vec_dot_ctrl #(
    parameter int C         = 16,
    parameter int W_X       = 8,
    parameter int W_K       = 8,
    parameter int MAX_BEATS = 64,
    parameter int W_Y       = W_X + W_K + $clog2(C),
    parameter int LATENCY   = $clog2(C) + 1,
    parameter int W_N       = $clog2(MAX_BEATS + 1),
    parameter int W_ACC     = W_Y + $clog2(MAX_BEATS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [W_N-1:0]          cfg_beats,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [C*W_X-1:0]        s_x,
    input  logic [C*W_K-1:0]        s_k,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [W_ACC-1:0] m_data,
    output logic                    busy
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    localparam logic [W_N-1:0] c_max_beats = W_N'(MAX_BEATS);

    state_t                  r_state;
    logic [W_N-1:0]          r_n;
    logic [W_N-1:0]          r_cnt;
    logic [LATENCY-1:0]      r_tag;
    logic signed [W_ACC-1:0] r_acc;

    logic                    w_accept;
    logic                    w_start_ok;
    logic [C*W_X-1:0]        w_mx;
    logic [C*W_K-1:0]        w_mk;
    logic signed [W_Y-1:0]   w_y;
    logic signed [W_ACC-1:0] w_acc_next;

    assign w_accept   = s_valid && s_ready;
    assign w_start_ok = start && (cfg_beats != '0) && (cfg_beats <= c_max_beats);
    assign w_mx       = w_accept ? s_x : '0;
    assign w_mk       = w_accept ? s_k : '0;
    assign w_acc_next = r_acc + (r_tag[LATENCY-1] ? {{(W_ACC-W_Y){w_y[W_Y-1]}}, w_y} : '0);

    vec_mul #(
        .C   (C),
        .W_X (W_X),
        .W_K (W_K),
        .W_Y (W_Y)
    ) u_vec_mul (
        .clk  (clk),
        .rst  (rst),
        .i_en (1'b1),
        .i_x  (w_mx),
        .i_k  (w_mk),
        .o_y  (w_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_n     <= '0;
            r_cnt   <= '0;
            r_tag   <= '0;
            r_acc   <= '0;
            s_ready <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
            busy    <= 1'b0;
        end else begin
            // Tag marks which vec_mul outputs belong to accepted beats.
            r_tag <= {r_tag[LATENCY-2:0], w_accept};
            r_acc <= w_acc_next;
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_n     <= cfg_beats;
                        r_cnt   <= '0;
                        r_acc   <= '0;
                        s_ready <= 1'b1;
                        busy    <= 1'b1;
                        r_state <= S_FEED;
                    end
                end
                S_FEED: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == r_n - 1'b1) begin
                            s_ready <= 1'b0;
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Leave once only the final tag (being accumulated now) remains.
                    if (r_tag[LATENCY-2:0] == '0) begin
                        m_valid <= 1'b1;
                        m_data  <= w_acc_next;
                        r_state <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire
